// File: rtl/entropy_src_enable_ctrl.sv
// Initiator side of the entropy_src delayed-enable handshake: MuBi4 enable to request, drain, cooldown, lock/busy.
// Define ENTROPY_SRC_DISABLE_TIMEOUT_EN to add a disable-acknowledge timeout with a terminal ERROR state.
module entropy_src_enable_ctrl #(
  parameter int unsigned TimeoutW     = 8,
  parameter int unsigned MinOffCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          module_enable_i,
  input  logic                enable_ack_i,
  input  logic [TimeoutW-1:0] timeout_limit_i,
  output logic                enable_req_o,
  output logic                cfg_locked_o,
  output logic                busy_o,
  output logic                mubi_err_o,
  output logic                timeout_err_o
);

  localparam int unsigned       OffCntW    = 4;
  localparam logic [3:0]        MuBi4True  = 4'h6;
  localparam logic [3:0]        MuBi4False = 4'h9;
  localparam logic [OffCntW-1:0] OffLoad   = OffCntW'(MinOffCycles - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ON_WAIT  = 3'd1,
    ACTIVE   = 3'd2,
    OFF_WAIT = 3'd3,
    COOLDOWN = 3'd4,
    ERROR    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [OffCntW-1:0]  off_cnt_q, off_cnt_d;
  logic                en_true;
  logic                mubi_valid;
  logic                timeout_hit;

  assign en_true    = (module_enable_i == MuBi4True);
  assign mubi_valid = en_true || (module_enable_i == MuBi4False);

`ifdef ENTROPY_SRC_DISABLE_TIMEOUT_EN
  logic [TimeoutW-1:0] to_cnt_q;
  logic                timeout_err_q;

  assign timeout_hit   = (timeout_limit_i != '0) && (to_cnt_q == timeout_limit_i);
  assign timeout_err_o = timeout_err_q;

  // Counts OFF_WAIT cycles with the ack still high; restarts on each entry, saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_d == OFF_WAIT && state_q != OFF_WAIT) begin
        to_cnt_q <= '0;
      end else if (state_q == OFF_WAIT && enable_ack_i && to_cnt_q != '1) begin
        to_cnt_q <= to_cnt_q + TimeoutW'(1);
      end
      if (state_d == ERROR) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_limit;

  assign unused_timeout_limit = ^timeout_limit_i;
  assign timeout_hit          = 1'b0;
  assign timeout_err_o        = 1'b0;
`endif

  // Next-state and cooldown counter.
  always_comb begin
    state_d   = state_q;
    off_cnt_d = off_cnt_q;
    case (state_q)
      IDLE: begin
        if (en_true && !enable_ack_i) state_d = ON_WAIT;
      end
      ON_WAIT: begin
        if (!en_true)          state_d = OFF_WAIT;
        else if (enable_ack_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!en_true) state_d = OFF_WAIT;
      end
      OFF_WAIT: begin
        if (!enable_ack_i) begin
          state_d   = COOLDOWN;
          off_cnt_d = OffLoad;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      COOLDOWN: begin
        // A rising ack here is a protocol violation: go back and drain again.
        if (enable_ack_i)            state_d = OFF_WAIT;
        else if (off_cnt_q == '0)    state_d = IDLE;
        else                         off_cnt_d = off_cnt_q - OffCntW'(1);
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      off_cnt_q    <= '0;
      enable_req_o <= 1'b0;
      cfg_locked_o <= 1'b0;
      busy_o       <= 1'b0;
      mubi_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_cnt_q    <= off_cnt_d;
      enable_req_o <= (state_d == ON_WAIT) || (state_d == ACTIVE);
      cfg_locked_o <= (state_d != IDLE);
      busy_o       <= (state_d == OFF_WAIT) || (state_d == COOLDOWN);
      mubi_err_o   <= !mubi_valid;
    end
  end

endmodule

// File: tb/tb_entropy_src_enable_ctrl.sv
// Self-checking bench for entropy_src_enable_ctrl: directed scenarios plus randomized traffic against a phase/timestamp model.
`timescale 1ns/1ps
module tb_entropy_src_enable_ctrl;

  localparam int unsigned TimeoutW = 8;
  localparam int unsigned MinOff   = 2;
  localparam logic [3:0]  MT       = 4'h6;
  localparam logic [3:0]  MF       = 4'h9;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [3:0]          module_enable_i;
  logic                enable_ack_i;
  logic [TimeoutW-1:0] timeout_limit_i;
  logic                enable_req_o, cfg_locked_o, busy_o, mubi_err_o, timeout_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  entropy_src_enable_ctrl #(.TimeoutW(TimeoutW), .MinOffCycles(MinOff)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .module_enable_i (module_enable_i),
    .enable_ack_i    (enable_ack_i),
    .timeout_limit_i (timeout_limit_i),
    .enable_req_o    (enable_req_o),
    .cfg_locked_o    (cfg_locked_o),
    .busy_o          (busy_o),
    .mubi_err_o      (mubi_err_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: handshake phase plus the cycle at which the phase began.
  typedef enum int {P_OFF, P_REQ, P_ON, P_DRAIN, P_REST, P_DEAD} phase_t;
  phase_t ph;
  int     cyc, t0;
  bit     m_mubi, m_terr, timeout_en;

  task automatic model_reset();
    ph = P_OFF; m_mubi = 1'b0; m_terr = 1'b0; cyc = 0; t0 = 0;
  endtask

  task automatic enter(input phase_t p);
    ph = p;
    t0 = cyc + 1;
  endtask

  task automatic model_step(input logic [3:0] me, input logic ack, input int lim);
    bit want;
    int el;
    want   = (me == MT);
    m_mubi = !(me == MT || me == MF);
    el     = cyc - t0;
    if (el > 255) el = 255;
    case (ph)
      P_OFF:   if (want && !ack) enter(P_REQ);
      P_REQ:   if (!want) enter(P_DRAIN); else if (ack) enter(P_ON);
      P_ON:    if (!want) enter(P_DRAIN);
      P_DRAIN: begin
        if (!ack) enter(P_REST);
        else if (timeout_en && lim != 0 && el == lim) begin enter(P_DEAD); m_terr = 1'b1; end
      end
      P_REST:  if (ack) enter(P_DRAIN); else if (el == int'(MinOff) - 1) enter(P_OFF);
      default: ;
    endcase
    cyc++;
  endtask

  function automatic logic [4:0] exp_vec();
    return {ph == P_REQ || ph == P_ON, ph != P_OFF, ph == P_DRAIN || ph == P_REST, m_mubi, m_terr};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {enable_req_o, cfg_locked_o, busy_o, mubi_err_o, timeout_err_o};
  endfunction

  // Drive inputs, let the DUT and the model take one edge, then sample 1ns later.
  task automatic step(input logic [3:0] me, input logic ack);
    module_enable_i = me;
    enable_ack_i    = ack;
    @(posedge clk_i);
    model_step(me, ack, int'(timeout_limit_i));
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; module_enable_i = MF; enable_ack_i = 1'b0;
    #3;
    model_reset();
    rst_i = 1'b0;
  endtask

  task automatic go_active();
    step(MT, 1'b0); step(MT, 1'b1); step(MT, 1'b1);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (dut_vec() !== 5'b0) begin n_bad++; $display("FAIL reset_state: got %b want 00000", dut_vec()); end
    do_reset();
  endtask

  task automatic test_enable();
    step(MF, 1'b0); step(MF, 1'b0);
    step(MT, 1'b0);
    n_cmp++;
    if (enable_req_o !== 1'b1 || cfg_locked_o !== 1'b1) begin
      n_bad++; $display("FAIL enable_latency: req/lock got %b%b want 11", enable_req_o, cfg_locked_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(MT, i >= 2);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL enable step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_disable_drain();
    int nbusy;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      step(MF, i < 6);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL drain step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      if (busy_o === 1'b1) nbusy++;
    end
    n_cmp++;
    if (nbusy != 6 + int'(MinOff) || cfg_locked_o !== 1'b0) begin
      n_bad++; $display("FAIL drain_busy_len: got %0d lock %b want %0d lock 0", nbusy, cfg_locked_o, 6 + MinOff);
    end
  endtask

  task automatic test_quick_reenable();
    int nlow;
    go_active();
    step(MF, 1'b1);
    nlow = 1;
    for (int i = 0; i < 20 && enable_req_o !== 1'b1; i++) begin
      step(MT, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL reenable step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      if (enable_req_o !== 1'b1) nlow++;
    end
    n_cmp++;
    if (nlow != 2 + int'(MinOff) || enable_req_o !== 1'b1) begin
      n_bad++; $display("FAIL reenable_low_time: got %0d req %b want %0d req 1", nlow, enable_req_o, 2 + MinOff);
    end
  endtask

  task automatic test_abort();
    do_reset();
    step(MT, 1'b0); step(MF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL abort step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      step(MF, 1'b0);
    end
    n_cmp++;
    if (cfg_locked_o !== 1'b0) begin n_bad++; $display("FAIL abort_idle: lock got %b want 0", cfg_locked_o); end
    // Abort coincident with the ack: must drain rather than go active.
    step(MT, 1'b0); step(MF, 1'b1);
    n_cmp++;
    if (enable_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL abort_vs_ack: req/busy got %b%b want 01", enable_req_o, busy_o);
    end
    for (int i = 0; i < 6; i++) begin
      step(MF, i < 2);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL abort_ack step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_mubi();
    int nerr;
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 3 ? 4'hA : MF, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL mubi step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      if (mubi_err_o === 1'b1) nerr++;
    end
    n_cmp++;
    if (nerr != 3) begin n_bad++; $display("FAIL mubi_err_len: got %0d want 3", nerr); end
  endtask

  task automatic test_stale_and_violation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(MT, 1'b1);
      n_cmp++;
      if (enable_req_o !== 1'b0) begin n_bad++; $display("FAIL stale_ack step%0d: req got %b want 0", i, enable_req_o); end
    end
    step(MT, 1'b0);
    n_cmp++;
    if (enable_req_o !== 1'b1) begin n_bad++; $display("FAIL stale_release: req got %b want 1", enable_req_o); end
    // Ack glitching high during cooldown must send us back to draining.
    step(MT, 1'b1); step(MF, 1'b1); step(MF, 1'b0); step(MF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL cooldown_ack step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      step(MF, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go_active();
    n_cmp++;
    if (enable_req_o !== 1'b1) begin n_bad++; $display("FAIL async_pre: req got %b want 1", enable_req_o); end
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== 5'b0) begin n_bad++; $display("FAIL async_reset: got %b want 00000", dut_vec()); end
    #2;
    model_reset();
    module_enable_i = MF; enable_ack_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    timeout_limit_i = 8'd5;
    go_active();
    step(MF, 1'b1);
    n = 0;
    for (int i = 0; i < 30 && timeout_err_o !== 1'b1; i++) begin
      step(MF, 1'b1);
      n++;
    end
`ifdef ENTROPY_SRC_DISABLE_TIMEOUT_EN
    n_cmp++;
    if (n != 6) begin n_bad++; $display("FAIL timeout_delay: got %0d want 6", n); end
    for (int i = 0; i < 5; i++) begin
      step(MT, 1'b0);
      n_cmp++;
      if (dut_vec() !== 5'b01001) begin n_bad++; $display("FAIL error_sticky step%0d: got %b want 01001", i, dut_vec()); end
    end
    do_reset();
    timeout_limit_i = 8'd0;
    go_active();
    for (int i = 0; i < 300; i++) step(MF, 1'b1);
    n_cmp++;
    if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL limit_zero: terr/busy got %b%b want 01", timeout_err_o, busy_o);
    end
`else
    n_cmp++;
    if (timeout_err_o !== 1'b0 || busy_o !== 1'b1 || n != 30) begin
      n_bad++; $display("FAIL no_timeout: terr/busy got %b%b after %0d want 01 after 30", timeout_err_o, busy_o, n);
    end
`endif
    for (int i = 0; i < 4; i++) step(MF, 1'b0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL timeout_exit: got %b want %b", dut_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    bit         sw;
    logic [3:0] me;
    logic       ack;
    do_reset();
    sw = 1'b0; ack = 1'b0;
    timeout_limit_i = timeout_en ? TimeoutW'($urandom_range(0, 12)) : 8'd7;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) sw = ~sw;
      me = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : (sw ? MT : MF);
      if ($urandom_range(0, 2) == 0) ack = enable_req_o;
      if ($urandom_range(0, 49) == 0) ack = ~ack;
      step(me, ack);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL random step%0d: got %b want %b", i, dut_vec(), exp_vec()); end
      if (ph == P_DEAD && $urandom_range(0, 9) == 0) begin
        do_reset();
        ack = 1'b0;
      end
    end
  endtask

  initial begin
`ifdef ENTROPY_SRC_DISABLE_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    model_reset();
    rst_i = 1'b1; module_enable_i = MF; enable_ack_i = 1'b0; timeout_limit_i = '0;
    #12;
    test_reset();
    test_enable();
    test_disable_drain();
    test_quick_reenable();
    test_abort();
    test_mubi();
    test_stale_and_violation();
    test_async_reset();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
